// File: rtl/rx_block_assembler.sv
// Collects a UART receive byte stream into an NBYTES-wide block with valid/ready output.
// Define RX_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES of inter-byte silence.
module rx_block_assembler #(
    parameter int NBYTES         = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      byte_valid,
    input  logic [7:0]                byte_in,
    input  logic                      frame_err,
    input  logic                      block_ready,
    output logic                      block_valid,
    output logic [8*NBYTES-1:0]       block_out,
    output logic [$clog2(NBYTES):0]   byte_count,
    output logic                      overrun,
    output logic                      abort
);
    localparam int BW = 8 * NBYTES;
    localparam int CW = $clog2(NBYTES) + 1;

    typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   shift_q, shift_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overrun_q, overrun_d;
    logic            abort_q, abort_d;
    logic            good_byte;
    logic            bad_byte;
    logic            timeout_hit;
    logic [BW-1:0]   shifted;

    assign good_byte = byte_valid & ~frame_err;
    assign bad_byte  = byte_valid & frame_err;
    // Shift form that also holds for a single-byte block.
    assign shifted   = (shift_q << 8) | BW'(byte_in);

`ifdef RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] timer_q, timer_d;

    assign timeout_hit = (state_q == COLLECT) && (timer_q == TW'(TIMEOUT_CYCLES - 1));

    // Timer runs only while a frame stays in COLLECT with no new byte.
    always_comb begin
        timer_d = '0;
        if (state_q == COLLECT && state_d == COLLECT && !good_byte)
            timer_d = timer_q + TW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) timer_q <= '0;
        else        timer_q <= timer_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d   = state_q;
        shift_d   = shift_q;
        count_d   = count_q;
        overrun_d = 1'b0;
        abort_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (good_byte) begin
                    shift_d = shifted;
                    count_d = CW'(1);
                    state_d = (NBYTES == 1) ? FULL : COLLECT;
                end
            end
            COLLECT: begin
                if (good_byte) begin
                    shift_d = shifted;
                    count_d = count_q + CW'(1);
                    if (count_q + CW'(1) == CW'(NBYTES))
                        state_d = FULL;
                end else if (bad_byte || timeout_hit) begin
                    count_d = '0;
                    abort_d = 1'b1;
                    state_d = IDLE;
                end
            end
            FULL: begin
                // A good byte arriving with the handshake starts the next frame.
                if (block_ready) begin
                    if (good_byte) begin
                        shift_d = shifted;
                        count_d = CW'(1);
                        state_d = (NBYTES == 1) ? FULL : COLLECT;
                    end else begin
                        count_d = '0;
                        state_d = IDLE;
                    end
                end
                if (byte_valid && (!block_ready || frame_err))
                    overrun_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the data register is reset too, since block_out must read zero out of reset.
            state_q   <= IDLE;
            shift_q   <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            abort_q   <= abort_d;
        end
    end

    assign block_valid = (state_q == FULL);
    assign block_out   = shift_q;
    assign byte_count  = count_q;
    assign overrun     = overrun_q;
    assign abort       = abort_q;

endmodule

// File: tb/tb_rx_block_assembler.sv
// Self-checking bench for rx_block_assembler: directed scenarios plus randomized traffic
// compared against a queue-based frame model.
module tb_rx_block_assembler;
    localparam int NBYTES         = 16;
    localparam int TIMEOUT_CYCLES = 20;
    localparam int BW             = 8 * NBYTES;
    localparam int CW             = $clog2(NBYTES) + 1;
`ifdef RX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_in = '0;
    logic          frame_err = 1'b0;
    logic          block_ready = 1'b0;
    logic          block_valid;
    logic [BW-1:0] block_out;
    logic [CW-1:0] byte_count;
    logic          overrun;
    logic          abort;

    rx_block_assembler #(.NBYTES(NBYTES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_in(byte_in),
        .frame_err(frame_err), .block_ready(block_ready), .block_valid(block_valid),
        .block_out(block_out), .byte_count(byte_count), .overrun(overrun), .abort(abort)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bytes of the current frame, a held-block flag and a silence counter.
    logic [7:0]    frame_q[$];
    bit            m_full;
    logic [BW-1:0] m_block;
    int            m_silent;
    bit            m_ov;
    bit            m_ab;

    task automatic check(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        frame_q.delete();
        m_full = 1'b0; m_block = '0; m_silent = 0; m_ov = 1'b0; m_ab = 1'b0;
    endtask

    task automatic model_push(input logic [7:0] b);
        frame_q.push_back(b);
        m_silent = 0;
        if (frame_q.size() == NBYTES) begin
            m_block = '0;
            for (int i = 0; i < NBYTES; i++) m_block[BW-1-8*i -: 8] = frame_q[i];
            frame_q.delete();
            m_full = 1'b1;
        end
    endtask

    task automatic model_step(input bit bv, input logic [7:0] b, input bit fe, input bit rdy);
        m_ov = 1'b0;
        m_ab = 1'b0;
        if (m_full) begin
            m_ov = bv && (!rdy || fe);
            if (rdy) begin
                m_full = 1'b0;
                if (bv && !fe) model_push(b);
            end
        end else if (bv && fe) begin
            m_ab = (frame_q.size() != 0);
            frame_q.delete();
            m_silent = 0;
        end else if (bv) begin
            model_push(b);
        end else if (TO_EN && frame_q.size() != 0) begin
            m_silent++;
            if (m_silent == TIMEOUT_CYCLES) begin
                m_ab = 1'b1;
                frame_q.delete();
                m_silent = 0;
            end
        end
    endtask

    task automatic check_outputs();
        int exp_cnt;
        exp_cnt = m_full ? NBYTES : frame_q.size();
        check("block_valid", BW'(block_valid), BW'(m_full));
        check("byte_count", BW'(byte_count), BW'(exp_cnt));
        check("overrun", BW'(overrun), BW'(m_ov));
        check("abort", BW'(abort), BW'(m_ab));
        if (m_full) check("block_out", block_out, m_block);
    endtask

    // Drive one cycle of inputs, step the model at the edge, compare 1 time unit later.
    task automatic cycle(input bit bv, input logic [7:0] b, input bit fe, input bit rdy);
        byte_valid  = bv;
        byte_in     = b;
        frame_err   = fe;
        block_ready = rdy;
        @(posedge clk);
        model_step(bv, b, fe, rdy);
        #1;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, rdy);
    endtask

    task automatic send_bytes(input int n, input logic [7:0] base, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b1, base + 8'(i), 1'b0, rdy);
    endtask

    initial begin
        bit dense;
        bit bv, fe, rdy;
        model_reset();
        #12;
        check("rst_valid", BW'(block_valid), '0);
        check("rst_block", block_out, '0);
        check("rst_count", BW'(byte_count), '0);
        check("rst_pulses", BW'({overrun, abort}), '0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Back-to-back frame with downstream ready.
        send_bytes(16, 8'h00, 1'b1);
        check("t1_valid", BW'(block_valid), BW'(1));
        check("t1_block", block_out, 128'h000102030405060708090A0B0C0D0E0F);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("t1_drain", BW'({block_valid, byte_count}), '0);

        // Stalled downstream: extra byte overruns, block held.
        send_bytes(16, 8'h00, 1'b0);
        idle(50, 1'b0);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        check("t2_overrun", BW'(overrun), BW'(1));
        check("t2_block", block_out, 128'h000102030405060708090A0B0C0D0E0F);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("t2_idle", BW'({block_valid, byte_count, overrun}), '0);

        // Byte coincident with the handshake opens the next frame.
        send_bytes(16, 8'h10, 1'b0);
        cycle(1'b1, 8'h55, 1'b0, 1'b1);
        check("t3_no_overrun", BW'(overrun), '0);
        check("t3_count", BW'(byte_count), BW'(1));
        send_bytes(15, 8'h01, 1'b0);
        check("t3_block", block_out, 128'h550102030405060708090A0B0C0D0E0F);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Framing error mid-frame aborts; following frame is clean.
        send_bytes(5, 8'h30, 1'b0);
        cycle(1'b1, 8'hEE, 1'b1, 1'b0);
        check("t4_abort", BW'(abort), BW'(1));
        check("t4_count", BW'(byte_count), '0);
        send_bytes(16, 8'hA0, 1'b0);
        check("t4_block", block_out, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Inter-byte silence.
        send_bytes(3, 8'h40, 1'b0);
        if (TO_EN) begin
            idle(TIMEOUT_CYCLES - 1, 1'b0);
            check("t5_pre_abort", BW'({abort, byte_count}), BW'(3));
            idle(1, 1'b0);
            check("t5_abort", BW'(abort), BW'(1));
            check("t5_count", BW'(byte_count), '0);
            send_bytes(3, 8'h50, 1'b0);
            idle(TIMEOUT_CYCLES - 1, 1'b0);
            cycle(1'b1, 8'h77, 1'b0, 1'b0);
            check("t5_byte_wins", BW'({abort, byte_count}), BW'(4));
        end else begin
            idle(2 * TIMEOUT_CYCLES, 1'b0);
            check("t5_persist", BW'({abort, byte_count}), BW'(3));
        end
        cycle(1'b1, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset mid-frame.
        send_bytes(8, 8'h60, 1'b0);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("t6_count", BW'(byte_count), '0);
        check("t6_outputs", BW'({block_valid, overrun, abort}), '0);
        check("t6_block", block_out, '0);
        @(posedge clk); #1;
        check("t6_no_abort", BW'(abort), '0);
        #2 reset = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic with alternating dense and sparse phases.
        dense = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) dense = ($urandom_range(0, 1) == 1);
            bv  = dense ? ($urandom_range(0, 9) < 5) : ($urandom_range(0, 39) == 0);
            fe  = bv && ($urandom_range(0, 24) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            cycle(bv, 8'($urandom), fe, rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_block_assembler.md
# rx_block_assembler

Receive-side serial-to-parallel stage mirroring the transmit PISO. Sits directly downstream of the UART receiver and collects its byte stream into a 128-bit ciphertext block for the decipher/CRC-check path. Presents the block with a valid/ready handshake, aborts partial frames on framing errors or inter-byte timeout, and flags overruns.

## Interface
- NBYTES, 16, bytes per block; block width is 8*NBYTES.
- TIMEOUT_CYCLES, 100000, max clk cycles between bytes inside a frame (≥2).
- clk  input  1  system clock, all logic rising-edge.
- reset  input  1  asynchronous, active-low; clears all state.
- byte_valid  input  1  one-cycle pulse from UART receiver: byte_in holds a new byte.
- byte_in  input  8  received byte.
- frame_err  input  1  qualifies byte_valid; byte had bad stop bit.
- block_ready  input  1  downstream can accept block.
- block_valid  output  1  block_out holds a complete block.
- block_out  output  8*NBYTES  assembled block; first received byte in bits [8*NBYTES-1 -: 8].
- byte_count  output  $clog2(NBYTES)+1  bytes held in current frame.
- overrun  output  1  one-cycle pulse: byte dropped.
- abort  output  1  one-cycle pulse: partial frame discarded.

## Operation
- States: IDLE (count 0), COLLECT (1..NBYTES-1 bytes), FULL (block_valid=1).
- Good byte (byte_valid & !frame_err): shift register shifts left 8, byte enters LSB; count+1.
- IDLE→COLLECT on first good byte; COLLECT→FULL when count reaches NBYTES; NBYTES=1 goes IDLE→FULL directly.
- FULL: block_out and count frozen; handshake completes on any cycle with block_valid & block_ready → IDLE.
- FULL with good byte and no handshake: byte dropped, overrun pulses, block unchanged.
- FULL with good byte and handshake same cycle: block transferred, byte becomes first byte of next frame (COLLECT, count=1); no overrun.
- frame_err byte in IDLE/COLLECT: byte discarded, count→0, IDLE; abort pulses only if count was nonzero. In FULL: ignored apart from overrun pulse.
- Timeout: counter cleared on each accepted byte, increments each cycle in COLLECT; at TIMEOUT_CYCLES-1 without a byte → abort pulse, IDLE, count 0. A byte arriving on the expiry cycle wins (no abort).
- Shift register contents below the active bytes are don't-care; only block_out in FULL is defined.

## Timing
- Reset values: block_valid 0, block_out 0, byte_count 0, overrun 0, abort 0, state IDLE, timer 0.
- Byte accepted at edge n → byte_count updated after edge n.
- NBYTES-th byte at edge n → block_valid=1 after edge n (one cycle latency).
- Handshake at edge m → block_valid=0 after edge m.
- overrun/abort: high exactly one cycle, after the causing edge.
- Reset assertion mid-frame or in FULL: immediate clear, partial data lost, no pulses.

## Configuration
- RX_TIMEOUT_EN defined: inter-byte timeout logic present as above.
- Undefined: no timer; COLLECT persists indefinitely until bytes, frame_err or reset; abort only from frame_err; TIMEOUT_CYCLES unused.

## Test plan
- Bytes 0x00..0x0F, block_ready=1 → block_out=0x000102030405060708090A0B0C0D0E0F, block_valid one cycle, count back to 0.
- Same frame with block_ready=0 for 50 cycles, then byte 0xAA → overrun pulse, block unchanged; raise ready → transfer, IDLE.
- FULL, byte 0x55 coincident with block_ready → no overrun, count=1, next 15 bytes form block starting 0x55.
- 5 bytes, then byte with frame_err=1 → abort pulse, count=0; following 16 bytes assemble cleanly.
- RX_TIMEOUT_EN, TIMEOUT_CYCLES=20: 3 bytes then silence → abort after 20 cycles from last byte; byte on cycle 19 → no abort.
- Reset low after 8 bytes → all outputs reset values immediately, no abort pulse.
